// File: rtl/cube_pkg.sv
// Shared types and widths for the cube512 nonce scanner.
package cube_pkg;

    localparam int CUBE_WORK_W   = 480;
    localparam int CUBE_NONCE_W  = 32;
    localparam int CUBE_TARGET_W = 64;
    localparam int CUBE_HASH_W   = 512;
    localparam int CUBE_LATENCY  = 222;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } scan_state_t;

    // A hash wins when its top 64 bits, read as unsigned, do not exceed the target.
    function automatic logic hash_wins(input logic [CUBE_TARGET_W-1:0] hash_top,
                                       input logic [CUBE_TARGET_W-1:0] target);
        return hash_top <= target;
    endfunction

endpackage

// File: rtl/cube_nonce_fifo.sv
// Small synchronous FIFO holding winning nonces; a pop frees a slot for a same-cycle push.
module cube_nonce_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cube512_nonce_scan.sv
// Nonce issue and hash check front end for the pipelined cube512 core.
// Optional CUBE_SCAN_STATS_EN adds the hash_count output.
module cube512_nonce_scan
    import cube_pkg::*;
#(
    parameter int LATENCY    = CUBE_LATENCY,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CUBE_WORK_W-1:0]   work_data,
    input  logic [CUBE_NONCE_W-1:0]  nonce_start,
    input  logic [CUBE_NONCE_W-1:0]  nonce_end,
    input  logic [CUBE_TARGET_W-1:0] target,
    output logic [CUBE_HASH_W-1:0]   core_data,
    input  logic [CUBE_HASH_W-1:0]   core_hash,
    output logic                     busy,
    output logic                     done,
    output logic                     found_valid,
    input  logic                     found_ready,
    output logic [CUBE_NONCE_W-1:0]  found_nonce,
    output logic                     overflow
`ifdef CUBE_SCAN_STATS_EN
    ,
    output logic [31:0]              hash_count
`endif
);

    scan_state_t               state;
    scan_state_t               next_state;
    logic [CUBE_WORK_W-1:0]    work_q;
    logic [CUBE_NONCE_W-1:0]   end_q;
    logic [CUBE_TARGET_W-1:0]  target_q;
    logic [CUBE_NONCE_W-1:0]   issue_nonce;
    logic [CUBE_NONCE_W-1:0]   next_nonce;
    logic [CUBE_NONCE_W-1:0]   chk_nonce;
    logic [LATENCY-1:0]        valid_dl;
    logic                      start_acc;
    logic                      check_valid;
    logic                      win;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;
    logic                      unused_hash_low;

    assign unused_hash_low = ^core_hash[CUBE_HASH_W-CUBE_TARGET_W-1:0];

    assign start_acc   = (state == ST_IDLE) && start && !abort;
    assign next_nonce  = issue_nonce + 32'd1;
    assign check_valid = valid_dl[LATENCY-1] && !abort;
    assign win         = check_valid &&
                         hash_wins(core_hash[CUBE_HASH_W-1 -: CUBE_TARGET_W], target_q);
    assign pop         = found_valid && found_ready;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign found_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start_acc) next_state = ST_SCAN;
            ST_SCAN: begin
                if (abort)                     next_state = ST_IDLE;
                else if (issue_nonce == end_q) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)              next_state = ST_IDLE;
                else if (valid_dl == '0) next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Issue side: candidates go out back to back, so the check side can recover
    // each nonce by counting valid tails instead of storing it alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q      <= '0;
            end_q       <= '0;
            target_q    <= '0;
            issue_nonce <= '0;
            core_data   <= '0;
        end else if (abort) begin
            core_data <= '0;
        end else if (start_acc) begin
            work_q      <= work_data;
            end_q       <= nonce_end;
            target_q    <= target;
            issue_nonce <= nonce_start;
            core_data   <= {work_data, nonce_start};
        end else if (state == ST_SCAN) begin
            if (issue_nonce == end_q) begin
                core_data <= '0;
            end else begin
                issue_nonce <= next_nonce;
                core_data   <= {work_q, next_nonce};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_dl  <= '0;
            chk_nonce <= '0;
            overflow  <= 1'b0;
        end else begin
            if (abort)                  valid_dl <= '0;
            else if (state == ST_SCAN)  valid_dl <= {valid_dl[LATENCY-2:0], 1'b1};
            else                        valid_dl <= {valid_dl[LATENCY-2:0], 1'b0};

            if (start_acc)        chk_nonce <= nonce_start;
            else if (check_valid) chk_nonce <= chk_nonce + 32'd1;

            if (start_acc)                        overflow <= 1'b0;
            else if (win && fifo_full && !pop)    overflow <= 1'b1;
        end
    end

`ifdef CUBE_SCAN_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   hash_count <= '0;
        else if (start_acc)                           hash_count <= '0;
        else if (check_valid && (hash_count != '1))   hash_count <= hash_count + 32'd1;
    end
`endif

    cube_nonce_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CUBE_NONCE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (win),
        .push_data (chk_nonce),
        .pop       (pop),
        .pop_data  (found_nonce),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_cube512_nonce_scan.sv
// Directed bench for cube512_nonce_scan against a LATENCY-deep model core whose hash top is the nonce.
module tb_cube512_nonce_scan;
    import cube_pkg::*;

    localparam int LAT   = 222;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [479:0] work_data;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [63:0]  target;
    logic [511:0] core_data;
    logic [511:0] core_hash;
    logic         busy;
    logic         done;
    logic         found_valid;
    logic         found_ready;
    logic [31:0]  found_nonce;
    logic         overflow;
`ifdef CUBE_SCAN_STATS_EN
    logic [31:0]  hash_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cube512_nonce_scan #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .work_data   (work_data),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .target      (target),
        .core_data   (core_data),
        .core_hash   (core_hash),
        .busy        (busy),
        .done        (done),
        .found_valid (found_valid),
        .found_ready (found_ready),
        .found_nonce (found_nonce),
        .overflow    (overflow)
`ifdef CUBE_SCAN_STATS_EN
        ,
        .hash_count  (hash_count)
`endif
    );

    // Model core: the nonce field travels LAT stages and lands in the hash top.
    logic [31:0] pipe [LAT];
    initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
    always @(posedge clk) begin
        pipe[0] <= core_data[31:0];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_hash = {32'h0, pipe[LAT-1], 448'h0};

    int          cyc = 0;
    int          start_cyc;
    int          done_cnt;
    int          done_cyc;
    int          issued;
    logic [31:0] popped [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (found_valid && found_ready) popped.push_back(found_nonce);
        if (core_data[511:32] != '0) issued++;
    end

    // Start is high for one cycle; returns one cycle after acceptance.
    task automatic applyStimulus(input logic [31:0] ns, input logic [31:0] ne, input logic [63:0] tgt);
        @(posedge clk); #1;
        done_cnt = 0;
        issued   = 0;
        popped.delete();
        nonce_start = ns;
        nonce_end   = ne;
        target      = tgt;
        start       = 1'b1;
        start_cyc   = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; found_ready = 1'b0;
        work_data = '0; nonce_start = '0; nonce_end = '0; target = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (found_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_found_valid: got %b expected 0", found_valid); end
        checks++; if (found_nonce !== 32'h0) begin errors++; $display("[TB] FAIL reset_found_nonce: got %h expected 0", found_nonce); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (core_data !== '0) begin errors++; $display("[TB] FAIL reset_core_data: got %h expected 0", core_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_nonce;
        bit to;
        work_data   = {15{32'hDEADBEEF}};
        found_ready = 1'b1;
        applyStimulus(32'd5, 32'd5, '1);
        checks++; if (core_data !== {work_data, 32'd5}) begin errors++; $display("[TB] FAIL single_core_data: got %h expected %h", core_data, {work_data, 32'd5}); end
        wait_idle(LAT + 20, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL single_timeout: busy still %b expected 0", busy); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL single_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc - start_cyc !== LAT + 3) begin errors++; $display("[TB] FAIL single_done_latency: got %0d expected %0d", done_cyc - start_cyc, LAT + 3); end
        checks++; if (issued !== 1) begin errors++; $display("[TB] FAIL single_issued: got %0d expected 1", issued); end
        checks++; if (popped.size() !== 1) begin errors++; $display("[TB] FAIL single_found_count: got %0d expected 1", popped.size()); end
        else begin
            checks++; if (popped[0] !== 32'd5) begin errors++; $display("[TB] FAIL single_found_nonce: got %h expected 5", popped[0]); end
        end
`ifdef CUBE_SCAN_STATS_EN
        checks++; if (hash_count !== 32'd1) begin errors++; $display("[TB] FAIL single_hash_count: got %0d expected 1", hash_count); end
`endif
    endtask

    task automatic test_range;
        bit to;
        work_data   = {15{32'h1234_5678}};
        found_ready = 1'b1;
        applyStimulus(32'd0, 32'd99, 64'd9);
        repeat (5) @(posedge clk);
        #1;
        nonce_start = 32'd500;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(400, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL range_timeout: busy still %b expected 0", busy); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL range_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc - start_cyc !== 100 + LAT + 2) begin errors++; $display("[TB] FAIL range_done_latency: got %0d expected %0d", done_cyc - start_cyc, 100 + LAT + 2); end
        checks++; if (issued !== 100) begin errors++; $display("[TB] FAIL range_issued: got %0d expected 100", issued); end
        checks++; if (popped.size() !== 10) begin errors++; $display("[TB] FAIL range_found_count: got %0d expected 10", popped.size()); end
        else begin
            for (int i = 0; i < 10; i++) begin
                checks++; if (popped[i] !== 32'(i)) begin errors++; $display("[TB] FAIL range_found_%0d: got %h expected %h", i, popped[i], 32'(i)); end
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL range_overflow: got %b expected 0", overflow); end
`ifdef CUBE_SCAN_STATS_EN
        checks++; if (hash_count !== 32'd100) begin errors++; $display("[TB] FAIL range_hash_count: got %0d expected 100", hash_count); end
`endif
    endtask

    task automatic test_wrap;
        bit to;
        logic [31:0] exp_n [4];
        exp_n = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        found_ready = 1'b1;
        applyStimulus(32'hFFFF_FFFE, 32'd1, '1);
        wait_idle(LAT + 30, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL wrap_timeout: busy still %b expected 0", busy); end
        checks++; if (issued !== 4) begin errors++; $display("[TB] FAIL wrap_issued: got %0d expected 4", issued); end
        checks++; if (popped.size() !== 4) begin errors++; $display("[TB] FAIL wrap_found_count: got %0d expected 4", popped.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (popped[i] !== exp_n[i]) begin errors++; $display("[TB] FAIL wrap_found_%0d: got %h expected %h", i, popped[i], exp_n[i]); end
            end
        end
    endtask

    task automatic test_overflow;
        bit to;
        @(posedge clk); #1;
        found_ready = 1'b0;
        applyStimulus(32'd0, 32'd9, '1);
        wait_idle(LAT + 40, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL ovf_timeout: busy still %b expected 0", busy); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (found_nonce !== 32'd0) begin errors++; $display("[TB] FAIL ovf_head: got %h expected 0", found_nonce); end
        @(posedge clk); #1;
        found_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        found_ready = 1'b0;
        checks++; if (popped.size() !== DEPTH) begin errors++; $display("[TB] FAIL ovf_held_count: got %0d expected %0d", popped.size(), DEPTH); end
        else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++; if (popped[i] !== 32'(i)) begin errors++; $display("[TB] FAIL ovf_held_%0d: got %h expected %h", i, popped[i], 32'(i)); end
            end
        end
        checks++; if (found_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained: got %b expected 0", found_valid); end
        found_ready = 1'b1;
        applyStimulus(32'd0, 32'd9, '1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear_on_start: got %b expected 0", overflow); end
        wait_idle(LAT + 40, to);
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ready_run: got %b expected 0", overflow); end
        checks++; if (popped.size() !== 10) begin errors++; $display("[TB] FAIL ovf_ready_count: got %0d expected 10", popped.size()); end
    endtask

    task automatic test_abort;
        bit to;
        bit seen;
        found_ready = 1'b1;
        applyStimulus(32'd0, 32'd199, '1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (core_data[31:0] == 32'd49) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL abort_reach_49: got %h expected 31", core_data[31:0]); end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got busy %b expected 0", busy); end
        checks++; if (core_data !== '0) begin errors++; $display("[TB] FAIL abort_core_data: got %h expected 0", core_data); end
        repeat (LAT + 40) @(negedge clk);
        checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt); end
        checks++; if (popped.size() !== 0) begin errors++; $display("[TB] FAIL abort_no_push: got %0d expected 0", popped.size()); end
        applyStimulus(32'd7, 32'd7, '1);
        wait_idle(LAT + 20, to);
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL abort_restart_done: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc - start_cyc !== LAT + 3) begin errors++; $display("[TB] FAIL abort_restart_latency: got %0d expected %0d", done_cyc - start_cyc, LAT + 3); end
        checks++; if (popped.size() !== 1) begin errors++; $display("[TB] FAIL abort_restart_count: got %0d expected 1", popped.size()); end
        else begin
            checks++; if (popped[0] !== 32'd7) begin errors++; $display("[TB] FAIL abort_restart_nonce: got %h expected 7", popped[0]); end
        end
    endtask

    task automatic test_reset_mid_drain;
        bit seen;
        @(posedge clk); #1;
        found_ready = 1'b0;
        applyStimulus(32'd0, 32'd9, '1);
        seen = 1'b0;
        for (int i = 0; i < LAT + 40; i++) begin
            @(negedge clk);
            if (overflow) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL drain_overflow_seen: got %b expected 1", overflow); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drain_busy: got %b expected 1", busy); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_drain_busy: got %b expected 0", busy); end
        checks++; if (found_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_drain_found_valid: got %b expected 0", found_valid); end
        checks++; if (found_nonce !== 32'h0) begin errors++; $display("[TB] FAIL rst_drain_found_nonce: got %h expected 0", found_nonce); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_drain_overflow: got %b expected 0", overflow); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_drain_done: got %b expected 0", done); end
        checks++; if (core_data !== '0) begin errors++; $display("[TB] FAIL rst_drain_core_data: got %h expected 0", core_data); end
`ifdef CUBE_SCAN_STATS_EN
        checks++; if (hash_count !== 32'd0) begin errors++; $display("[TB] FAIL rst_drain_hash_count: got %0d expected 0", hash_count); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_nonce();
        test_range();
        test_wrap();
        test_overflow();
        test_abort();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
